// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// LSB digit first, through a DIGIT-wide ripple of full-adder cells.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             state_o
);

   // Handshake: start is accepted only on an edge where busy=0; done pulses for
   // one cycle on the edge that completes the last digit and clears busy.
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

   logic [DIGIT+1:0] step;
   logic [DIGIT-1:0] dsum;
   logic             dcout, dcmsb;
   logic [WIDTH-1:0] res_next;
   logic             last_step;

   // Returns {carry into top bit, carry out, digit sum}.
   function automatic logic [DIGIT+1:0] digit_add(input logic [DIGIT-1:0] x,
                                                  input logic [DIGIT-1:0] y,
                                                  input logic             ci);
      logic [DIGIT:0]   c;
      logic [DIGIT-1:0] s;
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
      return {c[DIGIT-1], c[DIGIT], s};
   endfunction

   always_comb begin
      step      = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], c_q);
      dsum      = step[DIGIT-1:0];
      dcout     = step[DIGIT];
      dcmsb     = step[DIGIT+1];
      // New digit enters from the top so the LSB digit lands at bit 0 after N steps.
      res_next  = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
      last_step = (cnt_q == CW'(N - 1));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               c_d     = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            c_d   = dcout;
            res_d = res_next;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
               sum_d   = res_next;
               cout_d  = dcout;
               ovf_d   = dcout ^ dcmsb;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder in three shapes: 1/1, 8/1 and 8/4 (WIDTH/DIGIT),
// with a result queue filled at start and drained at done.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=1, DIGIT=1
   logic       s1_start, s1_sub, s1_cin, s1_busy, s1_done, s1_cout, s1_ovf, s1_st;
   logic [0:0] s1_a, s1_b, s1_sum;

   // index 0: WIDTH=8 DIGIT=1, index 1: WIDTH=8 DIGIT=4
   logic       st8[2], sub8[2], cin8[2], busy8[2], done8[2], cout8[2], ovf8[2], dbg8[2];
   logic [7:0] a8[2], b8[2], sum8[2], last8[2];

   logic [9:0] exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .a(s1_a), .b(s1_b),
      .cin(s1_cin), .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout),
      .overflow(s1_ovf), .state_o(s1_st));

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_b1 (
      .clk(clk), .rst_n(rst_n), .start(st8[0]), .sub(sub8[0]), .a(a8[0]), .b(b8[0]),
      .cin(cin8[0]), .busy(busy8[0]), .done(done8[0]), .sum(sum8[0]), .cout(cout8[0]),
      .overflow(ovf8[0]), .state_o(dbg8[0]));

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_b4 (
      .clk(clk), .rst_n(rst_n), .start(st8[1]), .sub(sub8[1]), .a(a8[1]), .b(b8[1]),
      .cin(cin8[1]), .busy(busy8[1]), .done(done8[1]), .sum(sum8[1]), .cout(cout8[1]),
      .overflow(ovf8[1]), .state_o(dbg8[1]));

   // Reference: plain integer addition; overflow from operand/result sign bits.
   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
      logic [7:0] bb;
      logic [8:0] full;
      logic       ov;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : cin);
      ov   = (a[7] == bb[7]) && (full[7] != a[7]);
      return {ov, full[8], full[7:0]};
   endfunction

   function automatic logic [9:0] model1(input logic a, input logic b, input logic cin);
      logic [1:0] full;
      logic       ov;
      full = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      ov   = (a == b) && (full[0] != a);
      return {ov, full[1], 8'(full[0])};
   endfunction

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic go8(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub, input bit at_neg);
      if (!at_neg) @(negedge clk);
      a8[d]   = a;
      b8[d]   = b;
      cin8[d] = cin;
      sub8[d] = sub;
      st8[d]  = 1'b1;
      exp_q.push_back(model8(a, b, cin, sub));
      @(posedge clk);
      @(negedge clk);
      st8[d] = 1'b0;
      chk("accept_busy", 10'(busy8[d]), 10'd1);
   endtask

   task automatic fin8(input int d, input int lat, input int n0, input bit chk_fall);
      int         n;
      bit         got;
      logic [9:0] e;
      n   = n0;
      got = 1'b0;
      while (!got && n < 64) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done8[d]) got = 1'b1;
      end
      chk("done_seen", 10'(got), 10'd1);
      chk("latency", 10'(n), 10'(lat));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
      chk("result", {ovf8[d], cout8[d], sum8[d]}, e);
      chk("idle_at_done", 10'(busy8[d]), 10'd0);
      last8[d] = e[7:0];
      if (chk_fall) begin
         @(posedge clk);
         @(negedge clk);
         chk("done_fall", 10'({busy8[d], done8[d]}), 10'd0);
      end
   endtask

   initial begin
      int seen;
      logic [9:0] e;
      s1_start = 0; s1_sub = 0; s1_cin = 0; s1_a = 0; s1_b = 0;
      for (int d = 0; d < 2; d++) begin
         st8[d] = 0; sub8[d] = 0; cin8[d] = 0; a8[d] = 0; b8[d] = 0; last8[d] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_w1", 10'({s1_busy, s1_done, s1_st, s1_ovf, s1_cout, s1_sum}), 10'd0);
      for (int d = 0; d < 2; d++)
         chk("rst_w8", {busy8[d], done8[d], dbg8[d], ovf8[d], cout8[d], sum8[d][4:0]}, 10'd0);
      chk("rst_sum0", 10'(sum8[0]), 10'd0);
      rst_n = 1'b1;

      // Full-adder truth table on the 1-bit instance.
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         s1_a = v[2]; s1_b = v[1]; s1_cin = v[0]; s1_start = 1'b1;
         exp_q.push_back(model1(v[2], v[1], v[0]));
         @(posedge clk);
         @(negedge clk);
         s1_start = 1'b0;
         chk("w1_busy", 10'({s1_busy, s1_done}), 10'b10);
         @(posedge clk);
         @(negedge clk);
         chk("w1_done", 10'({s1_busy, s1_done}), 10'b01);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
         chk("w1_result", {s1_ovf, s1_cout, 8'(s1_sum)}, e);
      end

      go8(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0); fin8(0, 8, 0, 1);
      go8(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0); fin8(0, 8, 0, 1);
      go8(0, 8'h05, 8'h07, 1'b0, 1'b1, 0); fin8(0, 8, 0, 1);
      go8(0, 8'h80, 8'h01, 1'b1, 1'b1, 0); fin8(0, 8, 0, 1);

      // DIGIT=4, then back-to-back start in the done cycle.
      go8(1, 8'h3C, 8'hC4, 1'b1, 1'b0, 0); fin8(1, 2, 0, 0);
      go8(1, 8'h01, 8'h02, 1'b0, 1'b0, 1); fin8(1, 2, 0, 1);

      // Start pulse mid-operation must be ignored; sum holds the prior result.
      go8(0, 8'h10, 8'h20, 1'b0, 1'b0, 0);
      repeat (2) begin @(posedge clk); @(negedge clk); end
      a8[0] = 8'hAA; b8[0] = 8'h55; st8[0] = 1'b1;
      chk("hold_sum", 10'(sum8[0]), 10'(last8[0]));
      @(posedge clk);
      @(negedge clk);
      st8[0] = 1'b0;
      chk("hold_sum2", 10'(sum8[0]), 10'(last8[0]));
      fin8(0, 8, 3, 1);

      // Reset in the middle of a run.
      go8(0, 8'h12, 8'h34, 1'b0, 1'b0, 0);
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      chk("abort_state", 10'({busy8[0], done8[0], dbg8[0]}), 10'd0);
      chk("abort_outs", {ovf8[0], cout8[0], sum8[0]}, 10'd0);
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (done8[0]) seen = 1;
      end
      chk("no_done_after_abort", 10'(seen), 10'd0);
      last8[0] = 8'h00;
      go8(0, 8'h9C, 8'h64, 1'b1, 1'b0, 0); fin8(0, 8, 0, 1);

      for (int k = 0; k < 6; k++) begin
         int d;
         d = k % 2;
         go8(d, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
         fin8(d, (d == 1) ? 2 : 8, 0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
